// File: rtl/fifo_pkg.sv
// Shared definitions for both sides of the asynchronous FIFO: default sizes and
// Gray/binary conversion helpers used by the read-empty and write-full logic.
package fifo_pkg;

    localparam int unsigned ASIZE_DEF = 4;
    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned GRAY_W    = 32;

    // Zero-extend narrower pointers into these and truncate the result; the
    // conversions are exact for any width up to GRAY_W.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// First-word-fall-through read port between the FIFO read side and the UART datapath.
interface rptr_empty_if #(
    parameter int unsigned DSIZE = fifo_pkg::DSIZE_DEF
);
    logic             rvalid;
    logic             rready;
    logic [DSIZE-1:0] rdata;

    modport master (output rvalid, output rdata, input  rready);
    modport slave  (input  rvalid, input  rdata, output rready);
endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter for a pointer of WIDTH bits.
module gray2bin #(
    parameter int unsigned WIDTH = fifo_pkg::ASIZE_DEF + 1
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    import fifo_pkg::*;

    assign bin = WIDTH'(fifo_pkg::gray2bin(GRAY_W'(gray)));

endmodule

// File: rtl/rptr_empty.sv
// Read-domain controller of the async FIFO: read pointers, registered empty/level/
// almost-empty status and a one-word FWFT output register.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned ASIZE    = ASIZE_DEF,
    parameter int unsigned DSIZE    = DSIZE_DEF,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   s_wptr,
    input  logic [DSIZE-1:0] rdata_mem,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic [ASIZE:0]   rlevel,
    output logic             ralmost_empty,
    rptr_empty_if.master     rd
);
    localparam int unsigned PW = ASIZE + 1;

    logic [PW-1:0]    rbin_q, rbin_d;
    logic [PW-1:0]    rgray_q, rgray_d;
    logic             rempty_q, rempty_d;
    logic             rvalid_q, rvalid_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic [PW-1:0]    rlevel_q, rlevel_d;
    logic             ralmost_empty_q, ralmost_empty_d;
    logic             fetch;
    logic [PW-1:0]    wbin;

    gray2bin #(.WIDTH(PW)) u_wptr_g2b (
        .gray (s_wptr),
        .bin  (wbin)
    );

    // NOTE: every signal is assigned on every pass through this block, so no
    // latch can be inferred; keep it that way when adding outputs.
    always_comb begin
        fetch           = !rempty_q && (!rvalid_q || rd.rready);
        rbin_d          = rbin_q + PW'(fetch);
        rgray_d         = PW'(bin2gray(GRAY_W'(rbin_d)));
        // Full-width compare: the MSB lap bit separates empty from a full lap.
        rempty_d        = (rgray_d == s_wptr);
        rvalid_d        = fetch || (rvalid_q && !rd.rready);
        rdata_d         = fetch ? rdata_mem : rdata_q;
        // RAM-side count tops out at 2^ASIZE, so adding the output word never wraps.
        rlevel_d        = (wbin - rbin_d) + PW'(rvalid_d);
        ralmost_empty_d = (rlevel_d <= PW'(AE_LEVEL));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rgray_q         <= '0;
            rempty_q        <= 1'b1;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            rlevel_q        <= '0;
            ralmost_empty_q <= 1'b1;
        end else begin
            rbin_q          <= rbin_d;
            rgray_q         <= rgray_d;
            rempty_q        <= rempty_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            rlevel_q        <= rlevel_d;
            ralmost_empty_q <= ralmost_empty_d;
        end
    end

    assign raddr         = rbin_q[ASIZE-1:0];
    assign rptr          = rgray_q;
    assign rempty        = rempty_q;
    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rd.rvalid     = rvalid_q;
    assign rd.rdata      = rdata_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Randomized bench for rptr_empty against a word-count/queue model of the FIFO read side.
module tb_rptr_empty;

    localparam int ASIZE = 4;
    localparam int DSIZE = 8;
    localparam int AE    = 2;
    localparam int DEPTH = 1 << ASIZE;
    localparam int PW    = ASIZE + 1;

    logic             rclk   = 1'b0;
    logic             rrst_n = 1'b1;
    logic [PW-1:0]    s_wptr = '0;
    logic [DSIZE-1:0] rdata_mem;
    logic [ASIZE-1:0] raddr;
    logic [PW-1:0]    rptr;
    logic             rempty;
    logic [PW-1:0]    rlevel;
    logic             ralmost_empty;
    logic [DSIZE-1:0] mem [DEPTH];

    rptr_empty_if #(.DSIZE(DSIZE)) rd_if ();

    rptr_empty #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AE_LEVEL(AE)) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .s_wptr        (s_wptr),
        .rdata_mem     (rdata_mem),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty),
        .rd            (rd_if)
    );

    always #5 rclk = ~rclk;
    assign rdata_mem = mem[raddr];

    // Model: words written/fetched as plain counts, pending RAM data as a queue.
    int               w_cnt, m_rd;
    bit               m_valid, m_empty;
    logic [DSIZE-1:0] m_data;
    logic [DSIZE-1:0] q [$];
    int               n_checks, n_fail;
    int               stream_idx;
    bit               stream_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] gray_of(input int n);
        int m;
        m = n % (2 * DEPTH);
        return PW'(m ^ (m >> 1));
    endfunction

    function automatic int exp_level();
        return (w_cnt - m_rd) + int'(m_valid);
    endfunction

    function automatic bit can_write();
        return (w_cnt - m_rd) < DEPTH;
    endfunction

    task automatic write_word(input logic [DSIZE-1:0] d);
        mem[w_cnt % DEPTH] = d;
        q.push_back(d);
        w_cnt++;
        s_wptr = gray_of(w_cnt);
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".rvalid"}, 32'(rd_if.rvalid), 32'(m_valid));
        if (m_valid) check({ph, ".rdata"}, 32'(rd_if.rdata), 32'(m_data));
        check({ph, ".rempty"}, 32'(rempty), 32'(m_empty));
        check({ph, ".rptr"}, 32'(rptr), 32'(gray_of(m_rd)));
        check({ph, ".raddr"}, 32'(raddr), 32'(m_rd % DEPTH));
        check({ph, ".rlevel"}, 32'(rlevel), 32'(exp_level()));
        check({ph, ".ralmost_empty"}, 32'(ralmost_empty), 32'(exp_level() <= AE));
    endtask

    task automatic step(input string ph);
        bit               fetch, pop;
        logic [DSIZE-1:0] pre_data;
        pre_data = rd_if.rdata;
        @(posedge rclk);
        pop   = m_valid && rd_if.rready;
        fetch = !m_empty && (!m_valid || rd_if.rready);
        if (pop && stream_mode) begin
            check({ph, ".stream_word"}, 32'(pre_data), 32'(stream_idx));
            stream_idx++;
        end
        if (fetch) begin
            m_data = q.pop_front();
            m_rd++;
        end
        m_valid = fetch || (m_valid && !rd_if.rready);
        m_empty = (m_rd == w_cnt);
        #1;
        check_outputs(ph);
    endtask

    task automatic do_reset(input string ph);
        rrst_n = 1'b0;
        w_cnt = 0; m_rd = 0; m_valid = 1'b0; m_empty = 1'b1;
        q.delete();
        s_wptr = '0;
        #1;
        check({ph, ".rvalid"}, 32'(rd_if.rvalid), 32'd0);
        check({ph, ".rdata"}, 32'(rd_if.rdata), 32'd0);
        check({ph, ".rempty"}, 32'(rempty), 32'd1);
        check({ph, ".rptr"}, 32'(rptr), 32'd0);
        check({ph, ".rlevel"}, 32'(rlevel), 32'd0);
        check({ph, ".ralmost_empty"}, 32'(ralmost_empty), 32'd1);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic drain(input string ph);
        rd_if.rready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && (m_valid || !m_empty); i++) step(ph);
        check({ph, ".drained_rempty"}, 32'(rempty), 32'd1);
        check({ph, ".drained_rvalid"}, 32'(rd_if.rvalid), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; stream_idx = 0; stream_mode = 1'b0;
        rd_if.rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        #2;
        do_reset("reset");
        step("idle");
        step("idle");

        // Single word: rempty falls at E1, word appears at E2.
        write_word(8'hA5);
        step("single_e1");
        check("single_e1.rempty_fell", 32'(rempty), 32'd0);
        step("single_e2");
        check("single_e2.rvalid", 32'(rd_if.rvalid), 32'd1);
        check("single_e2.rdata", 32'(rd_if.rdata), 32'hA5);
        check("single_e2.rptr", 32'(rptr), 32'd1);
        check("single_e2.rlevel", 32'(rlevel), 32'd1);

        // Backpressure fill to 17 words.
        while (w_cnt < 17) begin
            write_word(8'($urandom));
            step("bp_fill");
        end
        step("bp_hold");
        step("bp_hold");
        check("bp.rlevel", 32'(rlevel), 32'd17);
        check("bp.ralmost_empty", 32'(ralmost_empty), 32'd0);
        check("bp.rptr", 32'(rptr), 32'(gray_of(1)));
        check("bp.rdata_held", 32'(rd_if.rdata), 32'hA5);
        drain("bp_drain");

        // Simultaneous pop and fetch at level 3.
        rd_if.rready = 1'b0;
        write_word(8'h31); write_word(8'h32); write_word(8'h33);
        for (int i = 0; i < 3; i++) step("pf_fill");
        check("pf.rlevel3", 32'(rlevel), 32'd3);
        rd_if.rready = 1'b1;
        step("pf_pop");
        rd_if.rready = 1'b0;
        check("pf.rvalid", 32'(rd_if.rvalid), 32'd1);
        check("pf.rdata", 32'(rd_if.rdata), 32'h32);
        check("pf.rlevel", 32'(rlevel), 32'd2);
        drain("pf_drain");

        // Almost-empty threshold while draining from 4 words.
        rd_if.rready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'(8'h40 + i));
        for (int i = 0; i < 3; i++) step("ae_fill");
        check("ae.rlevel4", 32'(rlevel), 32'd4);
        check("ae.low_at4", 32'(ralmost_empty), 32'd0);
        rd_if.rready = 1'b1;
        step("ae_drain");
        check("ae.at3", 32'(ralmost_empty), 32'd0);
        step("ae_drain");
        check("ae.at2", 32'(ralmost_empty), 32'd1);
        step("ae_drain");
        check("ae.at1", 32'(ralmost_empty), 32'd1);
        step("ae_drain");
        check("ae.at0", 32'(ralmost_empty), 32'd1);
        check("ae.rlevel0", 32'(rlevel), 32'd0);

        // Streaming 40 incrementing words through both pointer wraps.
        do_reset("reset2");
        stream_mode = 1'b1;
        rd_if.rready = 1'b1;
        for (int i = 0; i < 200 && w_cnt < 40; i++) begin
            if (can_write()) write_word(8'(w_cnt));
            step("stream");
        end
        drain("stream_drain");
        check("stream.count", 32'(stream_idx), 32'd40);
        stream_mode = 1'b0;

        // Random traffic with a mid-stream asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            rd_if.rready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 3) == 0);
            if (can_write() && $urandom_range(0, 2) != 0) write_word(8'($urandom));
            step("rand");
            if (i == 1500) begin
                #2;
                do_reset("reset_mid");
            end
        end
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
